// File: rtl/alu_share_arbiter_pkg.sv
// Shared op codes and slot state encoding for the two-requester ALU arbiter.
package alu_share_arbiter_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_alu_core.sv
// Combinational ALU: ripple-carry add/sub (B inverted, carry-in 1 for sub), AND, XOR,
// plus Y86-style zero/sign/overflow flags.
module alu_core
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] r_o,
    output logic             zf_o,
    output logic             sf_o,
    output logic             of_o
);

    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;

    assign sub      = (op_i == ALU_SUB);
    assign bx       = sub ? ~b_i : b_i;
    assign carry[0] = sub;

    // Full-adder chain; the carry out of the top bit is never needed.
    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_fa
        assign carry[i+1] = (a_i[i] & bx[i]) | (carry[i] & (a_i[i] ^ bx[i]));
    end
    assign sum = a_i ^ bx ^ carry;

    always_comb begin
        r_o  = sum;
        of_o = 1'b0;
        case (op_i)
            ALU_ADD: begin
                r_o  = sum;
                of_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) & (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SUB: begin
                r_o  = sum;
                of_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) & (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_AND: r_o = a_i & b_i;
            ALU_XOR: r_o = a_i ^ b_i;
            default: r_o = sum;
        endcase
    end

    assign zf_o = (r_o == '0);
    assign sf_o = r_o[WIDTH-1];

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters with a single registered
// response slot; both sides use valid/ready so either can stall.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zf,
    output logic             rsp_sf,
    output logic             rsp_of
);

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             id_q;
    logic [WIDTH-1:0] result_q;
    logic             zf_q, sf_q, of_q;

    logic             gnt0, gnt1, can_accept, accept;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_r;
    logic             alu_zf, alu_sf, alu_of;

    // rr_q names the requester that wins when both are valid.
    assign gnt0       = req0_valid & (~req1_valid | ~rr_q);
    assign gnt1       = req1_valid & (~req0_valid |  rr_q);
    assign can_accept = (state_q == ST_IDLE) | rsp_ready;
    assign accept     = can_accept & (gnt0 | gnt1) & ~rst;

    assign alu_op = gnt1 ? req1_op : req0_op;
    assign alu_a  = gnt1 ? req1_a  : req0_a;
    assign alu_b  = gnt1 ? req1_b  : req0_b;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .op_i (alu_op),
        .a_i  (alu_a),
        .b_i  (alu_b),
        .r_o  (alu_r),
        .zf_o (alu_zf),
        .sf_o (alu_sf),
        .of_o (alu_of)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_q     <= 1'b0;
            id_q     <= 1'b0;
            result_q <= '0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (accept) begin
                id_q     <= gnt1;
                result_q <= alu_r;
                zf_q     <= alu_zf;
                sf_q     <= alu_sf;
                of_q     <= alu_of;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        if (accept) begin
            state_d = ST_FULL;
            rr_d    = ~gnt1;
        end else if (state_q == ST_FULL && rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        req0_ready = can_accept & gnt0 & ~rst;
        req1_ready = can_accept & gnt1 & ~rst;
        rsp_valid  = (state_q == ST_FULL);
        rsp_id     = id_q;
        rsp_result = result_q;
        rsp_zf     = zf_q;
        rsp_sf     = sf_q;
        rsp_of     = of_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed vectors push expected responses,
// a negedge monitor pops and compares every consumed response.
module tb_alu_share_arbiter;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_ = 2'b10, XOR_ = 2'b11;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    typedef struct packed {
        logic        id;
        logic [63:0] res;
        logic        zf;
        logic        sf;
        logic        of;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic        rsp_id, rsp_zf, rsp_sf, rsp_of;
    logic [63:0] rsp_result;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zf     (rsp_zf),
        .rsp_sf     (rsp_sf),
        .rsp_of     (rsp_of)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One clock: drive after the rising edge, check readies at the falling edge and
    // record the response the bench expects the granted requester to produce.
    task automatic step(input logic r,
                        input logic v0, input logic [1:0] op0, input logic [63:0] a0, input logic [63:0] b0,
                        input logic v1, input logic [1:0] op1, input logic [63:0] a1, input logic [63:0] b1,
                        input logic rrdy, input logic [1:0] exp_rdy,
                        input logic [63:0] e_res, input logic e_zf, input logic e_sf, input logic e_of);
        @(posedge clk);
        #1;
        rst = r;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready = rrdy;
        @(negedge clk);
        check("ready{1,0}", {62'd0, req1_ready, req0_ready}, {62'd0, exp_rdy});
        if (exp_rdy != 2'b00)
            q.push_back('{id: exp_rdy[1], res: e_res, zf: e_zf, sf: e_sf, of: e_of});
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            exp_t got;
            got = '{id: rsp_id, res: rsp_result, zf: rsp_zf, sf: rsp_sf, of: rsp_of};
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got %h expected none", got);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL rsp {id,result,zf,sf,of}: got %h expected %h", got, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset cycles: valid requests must see no ready.
        step(1, 1, ADD, 64'd1, 64'd1, 1, ADD, 64'd1, 64'd1, 0, 2'b00, 0, 0, 0, 0);
        step(1, 0, ADD, 0, 0, 0, ADD, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);

        // Fill the slot and hold it with rsp_ready low.
        step(0, 1, ADD, 64'd5, 64'd7, 0, ADD, 0, 0, 0, 2'b01, 64'd12, 0, 0, 0);
        step(0, 0, ADD, 0, 0, 0, ADD, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check("held rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("held rsp_result", rsp_result, 64'd12);

        // Reset mid-response with both requesters valid: no ready, response discarded.
        step(1, 1, ADD, 64'd5, 64'd7, 1, SUB, 64'd9, 64'd9, 0, 2'b00, 0, 0, 0, 0);
        q.delete();

        // rr_ptr back to 0: req0 wins a tie; slot cleared.
        step(0, 1, ADD, 64'd5, 64'd7, 1, SUB, 64'd9, 64'd9, 1, 2'b01, 64'd12, 0, 0, 0);
        check("post-reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("post-reset rsp_result", rsp_result, 64'd0);
        check("post-reset id/flags", {60'd0, rsp_id, rsp_zf, rsp_sf, rsp_of}, 64'd0);

        // Sub to zero, sub to negative, overflow cases.
        step(0, 0, ADD, 0, 0, 1, SUB, 64'd9, 64'd9, 1, 2'b10, 64'd0, 1, 0, 0);
        check("rsp_valid after accept", {63'd0, rsp_valid}, 64'd1);
        step(0, 0, ADD, 0, 0, 1, SUB, 64'd3, 64'd4, 1, 2'b10, ONES, 0, 1, 0);
        step(0, 1, ADD, MAXP, 64'd1, 0, ADD, 0, 0, 1, 2'b01, MINN, 0, 1, 1);
        step(0, 0, ADD, 0, 0, 1, SUB, MINN, 64'd1, 1, 2'b10, MAXP, 0, 0, 1);

        // Contention: grants alternate 0,1,0,1; losing requester holds its operation.
        step(0, 1, AND_, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1, XOR_, 64'h1234, 64'h1234,
             1, 2'b01, 64'hF000_F000_F000_F000, 0, 1, 0);
        step(0, 1, ADD, 64'd1, 64'd2, 1, XOR_, 64'h1234, 64'h1234, 1, 2'b10, 64'd0, 1, 0, 0);
        step(0, 1, ADD, 64'd1, 64'd2, 1, SUB, 64'd10, 64'd3, 1, 2'b01, 64'd3, 0, 0, 0);
        step(0, 1, XOR_, 64'hFF, 64'h0F, 1, SUB, 64'd10, 64'd3, 1, 2'b10, 64'd7, 0, 0, 0);

        // Backpressure: accept req0, then stall three cycles.
        step(0, 1, ADD, 64'd100, 64'd1, 1, SUB, 64'd2, 64'd5, 1, 2'b01, 64'd101, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, AND_, 64'd6, 64'd3, 1, SUB, 64'd2, 64'd5, 0, 2'b00, 0, 0, 0, 0);
            check("stall rsp_result", rsp_result, 64'd101);
            check("stall rsp_id/valid", {62'd0, rsp_id, rsp_valid}, 64'd1);
        end
        // Release: drain and accept req1 in the same cycle.
        step(0, 1, AND_, 64'd6, 64'd3, 1, SUB, 64'd2, 64'd5, 1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1, 0);
        step(0, 1, AND_, 64'd6, 64'd3, 0, ADD, 0, 0, 1, 2'b01, 64'd2, 0, 0, 0);
        check("reload rsp_valid", {63'd0, rsp_valid}, 64'd1);
        step(0, 0, ADD, 0, 0, 0, ADD, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        step(0, 0, ADD, 0, 0, 0, ADD, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        check("drained rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("scoreboard empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
